// File: rtl/fd_dram_sched.sv
// fd_dram_sched: two-port round-robin scheduler in front of a single DRAM
// bridge. It keeps one bridge transaction in flight and holds a one-record
// write-through buffer so that repeated reads of the same record complete
// without a bridge round trip.
//
// Handshake rules: a request is taken in the cycle where reqN_valid and
// reqN_ready are both high. Ready can only be high in S_IDLE. Once a port
// has asserted valid, it keeps valid and its request fields stable until
// ready is seen. The bridge takes a command on a one-cycle C_in_valid
// pulse and answers with a one-cycle C_out_valid pulse. The client receives
// a one-cycle resp_valid pulse and cannot stall it.
module fd_dram_sched #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_r_wb,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_r_wb,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              resp_valid,
  output logic              resp_port,
  output logic [DATA_W-1:0] resp_data,
  input  logic              flush,
  output logic              C_in_valid,
  output logic              C_r_wb,
  output logic [ADDR_W-1:0] C_addr,
  output logic [DATA_W-1:0] C_data_w,
  input  logic              C_out_valid,
  input  logic [DATA_W-1:0] C_data_r,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              state;
  logic                prio;
  logic                lat_port;
  logic                lat_r_wb;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic                buf_valid;
  logic [ADDR_W-1:0]   buf_addr;
  logic [DATA_W-1:0]   buf_data;

  logic                grant0;
  logic                grant1;
  logic                accept;
  logic                acc_port;
  logic                acc_r_wb;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;
  logic                hit;
  logic [DATA_W-1:0]   fill_data;

  assign dbg_state = state;

  // Round-robin grant: only offered in S_IDLE. When both ports are valid,
  // prio decides which one wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == S_IDLE) begin
      if (req0_valid && (!req1_valid || !prio)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 | grant1;
  assign acc_port   = grant1;
  assign acc_r_wb   = grant1 ? req1_r_wb  : req0_r_wb;
  assign acc_addr   = grant1 ? req1_addr  : req0_addr;
  assign acc_wdata  = grant1 ? req1_wdata : req0_wdata;

  // The hit check uses the buffer as it stands this cycle. A flush in the
  // same cycle only affects later accepts.
  assign hit = acc_r_wb && buf_valid && (buf_addr == acc_addr);

  // A read fills the buffer with bridge data. A write fills it with its own
  // data. This keeps the buffer write-through.
  assign fill_data = lat_r_wb ? C_data_r : lat_wdata;

  // Scheduler FSM, bridge command registers, response registers and record buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      prio       <= 1'b0;
      lat_port   <= 1'b0;
      lat_r_wb   <= 1'b1;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      buf_valid  <= 1'b0;
      buf_addr   <= '0;
      buf_data   <= '0;
      C_in_valid <= 1'b0;
      C_r_wb     <= 1'b1;
      C_addr     <= '0;
      C_data_w   <= '0;
      resp_valid <= 1'b0;
      resp_port  <= 1'b0;
      resp_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_port  <= acc_port;
            lat_r_wb  <= acc_r_wb;
            lat_addr  <= acc_addr;
            lat_wdata <= acc_wdata;
            prio      <= ~acc_port;
            if (hit) begin
              resp_valid <= 1'b1;
              resp_port  <= acc_port;
              resp_data  <= buf_data;
              state      <= S_RESP;
            end else begin
              C_in_valid <= 1'b1;
              C_r_wb     <= acc_r_wb;
              C_addr     <= acc_addr;
              C_data_w   <= acc_wdata;
              state      <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          C_in_valid <= 1'b0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (C_out_valid) begin
            buf_valid  <= 1'b1;
            buf_addr   <= lat_addr;
            buf_data   <= fill_data;
            resp_valid <= 1'b1;
            resp_port  <= lat_port;
            resp_data  <= fill_data;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          resp_valid <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      // A flush wins over a fill in the same cycle.
      if (flush) begin
        buf_valid <= 1'b0;
      end
    end
  end

endmodule
